bcd_serial_addsub: RTL and testbench

//   Parametrised N-digit packed-BCD adder/subtractor, digit-serial (one BCD digit per clock, LSD first).

---
 rtl/bcd_serial_addsub.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, least significant digit first.
// A negative difference is returned as its magnitude, produced by a ten's-complement pass over the sum.
module bcd_serial_addsub #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;

  logic [DIGITS-1:0] nib_bad;
  logic [3:0]        a_dig [DIGITS];
  logic [3:0]        b_dig [DIGITS];
  logic [3:0]        s_dig [DIGITS];

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign a_dig[gi]   = a_q[4*gi +: 4];
      assign b_dig[gi]   = b_q[4*gi +: 4];
      assign s_dig[gi]   = sum_q[4*gi +: 4];
      assign nib_bad[gi] = (a_dig[gi] > 4'd9) || (b_dig[gi] > 4'd9);
    end
  endgenerate

  // Returns {carry, digit}: any raw digit sum above 9 is pushed back into 0..9 by adding 6.
  function automatic logic [4:0] bcd_norm(input logic [4:0] t);
    logic [4:0] adj;
    adj = t + 5'd6;
    if (t > 5'd9) begin
      return {1'b1, adj[3:0]};
    end
    return {1'b0, t[3:0]};
  endfunction

  logic [3:0]   a_sel, b_sel, s_sel, bd, wr_digit;
  logic [4:0]   add_t, fix_t, add_r, fix_r;
  logic [W-1:0] sum_wr;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    s_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_sel = a_dig[i];
        b_sel = b_dig[i];
        s_sel = s_dig[i];
      end
    end
  end

  // Subtraction adds the nine's complement of B; the initial carry supplies the +1.
  assign bd       = mode_q ? (4'd9 - b_sel) : b_sel;
  assign add_t    = {1'b0, a_sel} + {1'b0, bd} + {4'b0000, carry_q};
  assign fix_t    = {1'b0, 4'd9 - s_sel} + {4'b0000, carry_q};
  assign add_r    = bcd_norm(add_t);
  assign fix_r    = bcd_norm(fix_t);
  assign wr_digit = (state_q == S_FIX) ? fix_r[3:0] : add_r[3:0];

  always_comb begin
    sum_wr = sum_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDXW'(i)) begin
        sum_wr[4*i +: 4] = wr_digit;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          idx_d   = '0;
          carry_d = mode ? ~cin : cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          neg_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        // Operand validity is judged on the latched copy during the first digit slot.
        if ((idx_q == '0) && (|nib_bad)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          sum_d = sum_wr;
          if (idx_q == LAST_IDX) begin
            if (!mode_q) begin
              cout_d  = add_r[4];
              state_d = S_DONE;
            end else if (add_r[4]) begin
              cout_d  = 1'b1;
              neg_d   = 1'b0;
              state_d = S_DONE;
            end else begin
              cout_d  = 1'b0;
              neg_d   = 1'b1;
              idx_d   = '0;
              carry_d = 1'b1;
              state_d = S_FIX;
            end
          end else begin
            idx_d   = idx_q + IDXW'(1);
            carry_d = add_r[4];
          end
        end
      end

      S_FIX: begin
        sum_d = sum_wr;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          carry_d = fix_r[4];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign neg   = neg_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: fixed vectors, random operations against a decimal model,
// and hand-written reset / busy-start sequences on a 3-digit and a 1-digit instance.
module tb_bcd_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, mode, cin;
  logic [11:0] a, b, sum;
  logic        ready, done, cout, neg, err;

  logic        start1, mode1, cin1;
  logic [3:0]  a1, b1, sum1;
  logic        ready1, done1, cout1, neg1, err1;

  bcd_serial_addsub #(.DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .cin(cin), .a(a), .b(b),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .neg(neg), .err(err)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .cin(cin1), .a(a1), .b(b1),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .neg(neg1), .err(err1)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic int bcd2int(input logic [11:0] v, input int digits);
    int r = 0;
    for (int i = digits - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] int2bcd(input int x, input int digits);
    logic [11:0] r = '0;
    int y = x;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer arithmetic on the operand values.
  task automatic model(input int digits, input bit m, input bit c, input logic [11:0] av,
                       input logic [11:0] bv, output logic [11:0] s, output bit co,
                       output bit ng, output bit er, output int lat);
    int modv = 1;
    int va, vb, t;
    bit bad = 0;
    for (int i = 0; i < digits; i++) begin
      modv = modv * 10;
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1;
    end
    s = '0; co = 0; ng = 0; er = 0; lat = digits;
    if (bad) begin
      er = 1; lat = 1;
    end else begin
      va = bcd2int(av, digits);
      vb = bcd2int(bv, digits);
      if (!m) begin
        t  = va + vb + int'(c);
        s  = int2bcd(t % modv, digits);
        co = (t >= modv);
      end else begin
        t = va - vb - int'(c);
        if (t >= 0) begin
          s = int2bcd(t, digits); co = 1;
        end else begin
          s = int2bcd((-t) % modv, digits); ng = 1; lat = 2 * digits;
        end
      end
    end
  endtask

  task automatic run_op(input bit one, input bit m, input bit c, input logic [11:0] av,
                        input logic [11:0] bv, output logic [11:0] s, output bit co,
                        output bit ng, output bit er, output int lat);
    @(negedge clk);
    chk("ready_idle", one ? ready1 : ready, 1);
    if (one) begin
      start1 = 1; mode1 = m; cin1 = c; a1 = av[3:0]; b1 = bv[3:0];
    end else begin
      start = 1; mode = m; cin = c; a = av; b = bv;
    end
    @(posedge clk); #1;
    start = 0; start1 = 0;
    chk("ready_busy", one ? ready1 : ready, 0);
    a = 12'($urandom); b = 12'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
    mode = ~m; cin = ~c; mode1 = ~m; cin1 = ~c;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(one ? done1 : done) && lat < 20);
    s  = one ? {8'h00, sum1} : sum;
    co = one ? cout1 : cout;
    ng = one ? neg1 : neg;
    er = one ? err1 : err;
    @(posedge clk); #1;
    chk("done_pulse", one ? done1 : done, 0);
    chk("ready_back", one ? ready1 : ready, 1);
  endtask

  task automatic check_op(input string name, input bit one, input bit m, input bit c,
                          input logic [11:0] av, input logic [11:0] bv, input logic [11:0] es,
                          input bit eco, input bit eng, input bit eer, input int elat);
    logic [11:0] s;
    bit co, ng, er;
    int lat;
    run_op(one, m, c, av, bv, s, co, ng, er, lat);
    $display("op %s d=%0d %s a=%h b=%h cin=%0d -> sum=%h cout=%0d neg=%0d err=%0d lat=%0d",
             name, one ? 1 : 3, m ? "sub" : "add", av, bv, c, s, co, ng, er, lat);
    chk({name, ".sum"}, s, es);
    chk({name, ".cout"}, co, eco);
    chk({name, ".neg"}, ng, eng);
    chk({name, ".err"}, er, eer);
    chk({name, ".lat"}, lat, elat);
  endtask

  typedef struct {
    bit          m;
    bit          c;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] s;
    bit          co;
    bit          ng;
    bit          er;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [11:0] ra, rb, es;
    bit rm, rc, eco, eng, eer;
    int elat, ndone;

    vecs[0] = '{0, 1, 12'h999, 12'h999, 12'h999, 1, 0, 0, 3};
    vecs[1] = '{0, 0, 12'h682, 12'h835, 12'h517, 1, 0, 0, 3};
    vecs[2] = '{0, 0, 12'h451, 12'h069, 12'h520, 0, 0, 0, 3};
    vecs[3] = '{1, 0, 12'h835, 12'h682, 12'h153, 1, 0, 0, 3};
    vecs[4] = '{1, 0, 12'h000, 12'h000, 12'h000, 1, 0, 0, 3};
    vecs[5] = '{1, 0, 12'h682, 12'h835, 12'h153, 0, 1, 0, 6};
    vecs[6] = '{1, 1, 12'h000, 12'h000, 12'h001, 0, 1, 0, 6};
    vecs[7] = '{0, 0, 12'h9A3, 12'h001, 12'h000, 0, 0, 1, 1};
    vecs[8] = '{1, 1, 12'h000, 12'h999, 12'h000, 0, 1, 0, 6};

    rst = 1; start = 0; mode = 0; cin = 0; a = '0; b = '0;
    start1 = 0; mode1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", ready, 1);
    chk("rst.done", done, 0);
    chk("rst.sum", sum, 0);
    chk("rst.flags", {cout, neg, err}, 0);
    chk("rst.ready1", ready1, 1);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 9; i++)
      check_op($sformatf("vec%0d", i), 0, vecs[i].m, vecs[i].c, vecs[i].a, vecs[i].b,
               vecs[i].s, vecs[i].co, vecs[i].ng, vecs[i].er, vecs[i].lat);

    check_op("d1_add", 1, 0, 0, 12'h009, 12'h009, 12'h008, 1, 0, 0, 1);
    check_op("d1_sub", 1, 1, 0, 12'h003, 12'h007, 12'h004, 0, 1, 0, 2);

    for (int i = 0; i < 40; i++) begin
      ra = int2bcd($urandom_range(999), 3);
      rb = int2bcd($urandom_range(999), 3);
      if ($urandom_range(9) == 0) ra[4*$urandom_range(2) +: 4] = 4'($urandom_range(15, 10));
      rm = 1'($urandom); rc = 1'($urandom);
      model(3, rm, rc, ra, rb, es, eco, eng, eer, elat);
      check_op($sformatf("rnd%0d", i), 0, rm, rc, ra, rb, es, eco, eng, eer, elat);
    end

    for (int i = 0; i < 12; i++) begin
      ra = {8'h00, 4'($urandom_range(9))};
      rb = {8'h00, 4'($urandom_range(9))};
      rm = 1'($urandom); rc = 1'($urandom);
      model(1, rm, rc, ra, rb, es, eco, eng, eer, elat);
      check_op($sformatf("rnd1_%0d", i), 1, rm, rc, ra, rb, es, eco, eng, eer, elat);
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1; mode = 1; cin = 0; a = 12'h682; b = 12'h835;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("midrst.ready", ready, 1);
    chk("midrst.done", done, 0);
    chk("midrst.sum", sum, 0);
    chk("midrst.flags", {cout, neg, err}, 0);
    @(negedge clk);
    rst = 0;
    ndone = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst.no_done", ndone, 0);
    $display("op midrst: reset during ADD, done pulses afterwards=%0d", ndone);

    // Start held high while busy, with inputs changing after acceptance.
    @(negedge clk);
    start = 1; mode = 0; cin = 0; a = 12'h123; b = 12'h456;
    @(posedge clk); #1;
    a = 12'h999; b = 12'h999; mode = 1; cin = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 0;
    elat = 2;
    while (!done && elat < 20) begin
      @(posedge clk); #1;
      elat++;
    end
    $display("op busy: 123+456 with start held -> sum=%h cout=%0d lat=%0d", sum, cout, elat);
    chk("busy.lat", elat, 3);
    chk("busy.sum", sum, 12'h579);
    chk("busy.cout", cout, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("busy.hold_sum", sum, 12'h579);
    chk("busy.idle", ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
